// File: rtl/microseq_pkg.sv
// microseq_pkg: shared definitions for the microsequencer.
//   mode_e                - next-state mode encoding driven on 'select'
//   DEFAULT_DISPATCH_BASE - base microstate that icode dispatch offsets from
package microseq_pkg;

  typedef enum logic [2:0] {
    MODE_INC      = 3'd0,
    MODE_DISPATCH = 3'd1,
    MODE_JUMP     = 3'd2,
    MODE_WAIT     = 3'd3,
    MODE_CALL     = 3'd4,
    MODE_RET      = 3'd5,
    MODE_FETCH    = 3'd6,
    MODE_HOLD     = 3'd7
  } mode_e;

  localparam int unsigned DEFAULT_DISPATCH_BASE = 32'h10;

endpackage

// File: rtl/microseq_stack.sv
// microseq_stack: return-address LIFO for the microsequencer.
//   clk, reset - clock and synchronous active-high reset (clears occupancy only)
//   push, pop  - push pushData / discard top entry; ignored when full / empty
//   pushData   - entry to push
//   top        - most recently pushed entry (undefined while empty)
//   full/empty - occupancy flags
//   depth      - number of valid entries, 0..STACK_DEPTH
module microseq_stack
  import microseq_pkg::*;
#(
  parameter int unsigned STATE_W     = 6,
  parameter int unsigned STACK_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  logic                         pop,
  input  logic [STATE_W-1:0]           pushData,
  output logic [STATE_W-1:0]           top,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(STACK_DEPTH):0] depth
);

  localparam int unsigned IDX_W = $clog2(STACK_DEPTH);
  localparam int unsigned DEP_W = IDX_W + 1;

  logic [STATE_W-1:0] mem [STACK_DEPTH];
  logic [IDX_W-1:0]   wrIdx;
  logic [IDX_W-1:0]   topIdx;
  logic               doPush;
  logic               doPop;

  assign full   = (depth == DEP_W'(STACK_DEPTH));
  assign empty  = (depth == '0);
  assign doPush = push && !full;
  assign doPop  = pop && !empty;

  // Depth doubles as the write pointer; the top entry sits one below it.
  assign wrIdx  = depth[IDX_W-1:0];
  assign topIdx = wrIdx - IDX_W'(1);
  assign top    = mem[topIdx];

  always_ff @(posedge clk) begin
    if (reset) begin
      depth <= '0;
    end else if (doPush) begin
      depth <= depth + DEP_W'(1);
    end else if (doPop) begin
      depth <= depth - DEP_W'(1);
    end
  end

  // Entry storage is not reset: contents are don't-care until pushed.
  always_ff @(posedge clk) begin
    if (doPush && !reset) begin
      mem[wrIdx] <= pushData;
    end
  end

endmodule

// File: rtl/microseq_engine.sv
// microseq_engine: microprogram sequencer with dispatch, wait and call/return.
//   clk, reset - clock and synchronous active-high reset
//   select     - next-state mode (mode_e)
//   icode      - instruction code for DISPATCH
//   valN       - explicit target for JUMP / WAIT / CALL
//   ready      - per-channel memory-ready flags (ch0 DMem, ch1 IMem)
//   ready_sel  - ready channel tested in WAIT
//   state      - registered current microstate
//   stall      - combinational: WAIT selected and chosen channel not ready
//   depth      - return-stack occupancy
//   stack_err  - sticky overflow/underflow flag, cleared only by reset
module microseq_engine
  import microseq_pkg::*;
#(
  parameter int unsigned STATE_W       = 6,
  parameter int unsigned ICODE_W       = 4,
  parameter int unsigned NREADY        = 2,
  parameter int unsigned STACK_DEPTH   = 4,
  parameter int unsigned DISPATCH_BASE = DEFAULT_DISPATCH_BASE
) (
  input  logic                                            clk,
  input  logic                                            reset,
  input  logic [2:0]                                      select,
  input  logic [ICODE_W-1:0]                              icode,
  input  logic [STATE_W-1:0]                              valN,
  input  logic [NREADY-1:0]                               ready,
  input  logic [((NREADY > 1) ? $clog2(NREADY) : 1)-1:0]  ready_sel,
  output logic [STATE_W-1:0]                              state,
  output logic                                            stall,
  output logic [$clog2(STACK_DEPTH):0]                    depth,
  output logic                                            stack_err
);

  localparam logic [STATE_W-1:0] BASE = STATE_W'(DISPATCH_BASE);

  mode_e              mode;
  logic [STATE_W-1:0] stateNext;
  logic [STATE_W-1:0] stateInc;
  logic [STATE_W-1:0] stackTop;
  logic               stackFull;
  logic               stackEmpty;
  logic               readyOk;
  logic               push;
  logic               pop;
  logic               errEvent;

  assign mode     = mode_e'(select);
  assign stateInc = state + STATE_W'(1);

  // Out-of-range channel selects read as not ready.
  always_comb begin
    readyOk = 1'b0;
    if (32'(ready_sel) < NREADY) begin
      readyOk = ready[ready_sel];
    end
  end

  microseq_stack #(
    .STATE_W     (STATE_W),
    .STACK_DEPTH (STACK_DEPTH)
  ) uStack (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .pop      (pop),
    .pushData (stateInc),
    .top      (stackTop),
    .full     (stackFull),
    .empty    (stackEmpty),
    .depth    (depth)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= '0;
    end else begin
      state <= stateNext;
    end
  end

  // Next-state mux
  always_comb begin
    stateNext = state;
    unique case (mode)
      MODE_INC:      stateNext = stateInc;
      MODE_DISPATCH: stateNext = BASE + STATE_W'(icode);
      MODE_JUMP:     stateNext = valN;
      MODE_WAIT:     stateNext = readyOk ? valN : state;
      MODE_CALL:     stateNext = valN;
      MODE_RET:      stateNext = stackEmpty ? '0 : stackTop;
      MODE_FETCH:    stateNext = '0;
      MODE_HOLD:     stateNext = state;
      default:       stateNext = state;
    endcase
  end

  // Outputs and stack control
  always_comb begin
    stall    = (mode == MODE_WAIT) && !readyOk;
    push     = (mode == MODE_CALL) && !stackFull;
    pop      = (mode == MODE_RET) && !stackEmpty;
    errEvent = ((mode == MODE_CALL) && stackFull) ||
               ((mode == MODE_RET) && stackEmpty);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stack_err <= 1'b0;
    end else if (errEvent) begin
      stack_err <= 1'b1;
    end
  end

endmodule

// File: doc/microseq_engine.md
MICROSEQ_ENGINE -- requirements
Module: microseq_engine

Interface
REQ-001 Parameter STATE_W, default 6, width of the microstate and of valN.
REQ-002 Parameter ICODE_W, default 4, width of icode.
REQ-003 Parameter NREADY, default 2, number of ready channels (ch0 = DMemReady, ch1 = IMemReady).
REQ-004 Parameter STACK_DEPTH, default 4, return-stack entries (power of two, ≥2).
REQ-005 Parameter DISPATCH_BASE, default 6'h10, base microstate for icode dispatch.
REQ-006 clk  input  1  single clock; all state updates on rising edge.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 select  input  3  next-state mode, encoding per REQ-013.
REQ-009 icode  input  ICODE_W  instruction code for DISPATCH.
REQ-010 valN  input  STATE_W  explicit target microstate.
REQ-011 ready  input  NREADY  per-channel memory-ready flags.
REQ-012 ready_sel  input  clog2(NREADY) (min 1)  channel tested in WAIT.
REQ-013 Mode encoding: 0 INC, 1 DISPATCH, 2 JUMP, 3 WAIT, 4 CALL, 5 RET, 6 FETCH, 7 HOLD.
REQ-014 state  output  STATE_W  registered current microstate.
REQ-015 stall  output  1  combinational; high when select==WAIT and the selected ready is low.
REQ-016 depth  output  clog2(STACK_DEPTH)+1  registered return-stack occupancy.
REQ-017 stack_err  output  1  sticky overflow/underflow flag.

Function
REQ-018 state updates once per clk edge per mode; latency from select to state is exactly one cycle.
REQ-019 INC: state <= state+1, modulo 2^STATE_W (all-ones wraps to 0).
REQ-020 DISPATCH: state <= (DISPATCH_BASE + zero-extended icode) truncated to STATE_W.
REQ-021 JUMP: state <= valN.
REQ-022 WAIT: if ready[ready_sel]=1, state <= valN; else state holds and stall=1.
REQ-023 WAIT with ready_sel ≥ NREADY: treated as ready low (holds indefinitely).
REQ-024 CALL: push state+1 (wrapped), state <= valN, depth+1.
REQ-025 CALL when depth==STACK_DEPTH: jump still taken, no push, depth unchanged, stack_err <= 1.
REQ-026 RET: state <= top entry, pop, depth-1.
REQ-027 RET when depth==0: state <= 0, depth stays 0, stack_err <= 1.
REQ-028 FETCH: state <= 0; stack contents and depth unchanged.
REQ-029 HOLD: state, depth unchanged.
REQ-030 stack_err stays set until reset.
REQ-031 Ready inputs are sampled only in WAIT; ready changes in other modes have no effect.

Reset
REQ-032 On a clk edge with reset=1: state <= 0, depth <= 0, stack_err <= 0; all other inputs ignored that cycle.
REQ-033 Reset asserted mid-WAIT or mid-subroutine abandons the operation; return-stack entries become don't-care.
REQ-034 stall follows REQ-015 during reset (combinational), but it has no effect on state.

Structure
REQ-035 Package microseq_pkg holds the mode encoding constants (MODE_INC … MODE_HOLD) and the default DISPATCH_BASE.
REQ-036 Sub-module microseq_stack is the parametrised LIFO (STATE_W × STACK_DEPTH) with push, pop, full, empty, top and depth.
REQ-037 Top level contains only the next-state mux, the state register, stack control and the error flag.

Verification
REQ-038 Reset, then INC ×3 from 0 -> state 1, 2, 3; force state 6'h3F, then INC -> 0.
REQ-039 icode=4'h7, DISPATCH -> state 6'h17; icode=4'hF -> 6'h1F; DISPATCH_BASE=6'h38 with icode=4'hF -> 6'h07 (wrap).
REQ-040 WAIT, ready_sel=0, valN=6'h03, ready=2'b00 for 3 cycles -> state held and stall=1; ready=2'b01 -> state 6'h03 next cycle, stall=0.
REQ-041 From state 6'h05, CALL valN=6'h20 -> state 6'h20, depth 1; RET -> state 6'h06, depth 0, stack_err 0.
REQ-042 Five nested CALLs (depth 4) -> 5th taken, depth 4, stack_err 1; RET on empty -> state 0, stack_err stays 1 until reset.
REQ-043 reset=1 during WAIT with depth 2 -> next cycle state 0, depth 0, stack_err 0, stall follows select/ready.
